uart_brg_frac: RTL and testbench

- Next-generation UART baud rate generator.
- Same two-stage structure as the existing BRG: prescaler (divide by PS+1) followed by divider (divide by Div+1).
- Parametrised counter widths, a fractional divisor accumulator for low-error baud rates from arbitrary oscillators, a bit-rate enable derived from the oversampling enable, and shadowed settings with explicit load.
- Feeds CE_16x / CE_1x to the SSP UART transmitter and receiver.

---
 rtl/uart_brg_frac.sv | 83 ++++++++
 tb/tb_uart_brg_frac.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/uart_brg_frac.sv
// uart_brg_frac: prescaler + fractional divider baud generator producing CE_16x / CE_1x enables.
// Define BRG_AUTO_RELOAD_EN to re-sample PS/Div/Frac into the shadows on every terminal event.
module uart_brg_frac #(
    parameter int PS_W   = 4,
    parameter int DIV_W  = 8,
    parameter int FRAC_W = 4,
    parameter int OVS    = 16
) (
    input  logic              Clk,
    input  logic              Rst_N,
    input  logic              En,
    input  logic              Ld,
    input  logic [PS_W-1:0]   PS,
    input  logic [DIV_W-1:0]  Div,
    input  logic [FRAC_W-1:0] Frac,
    output logic              CE_16x,
    output logic              CE_1x
);
    localparam int PH_W = $clog2(OVS);

    logic [PS_W-1:0]   ps_q, ps_cnt, ps_nx;
    logic [DIV_W-1:0]  div_q, div_nx;
    logic [FRAC_W-1:0] frac_q, frac_nx, acc, acc_sum;
    logic [DIV_W:0]    div_cnt;
    logic [PH_W-1:0]   phase;
    logic              tick, term, carry;

    assign tick = En && ps_cnt == '0;
    assign term = tick && div_cnt == '0;
    assign {carry, acc_sum} = {1'b0, acc} + {1'b0, frac_q};

`ifdef BRG_AUTO_RELOAD_EN
    assign ps_nx   = PS;
    assign div_nx  = Div;
    assign frac_nx = Frac;
`else
    assign ps_nx   = ps_q;
    assign div_nx  = div_q;
    assign frac_nx = frac_q;
`endif

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            ps_q    <= '0;
            div_q   <= '0;
            frac_q  <= '0;
            ps_cnt  <= '0;
            div_cnt <= '0;
            acc     <= '0;
            phase   <= '0;
            CE_16x  <= 1'b0;
            CE_1x   <= 1'b0;
        end else if (Ld) begin
            ps_q    <= PS;
            div_q   <= Div;
            frac_q  <= Frac;
            ps_cnt  <= PS;
            div_cnt <= {1'b0, Div};
            acc     <= '0;
            phase   <= '0;
            CE_16x  <= 1'b0;
            CE_1x   <= 1'b0;
        end else begin
            CE_16x <= term;
            CE_1x  <= term && phase == PH_W'(OVS - 1);
            if (tick)
                ps_cnt <= term ? ps_nx : ps_q;
            else if (En)
                ps_cnt <= ps_cnt - 1'b1;
            // the carry produced by this period's accumulation stretches the next period
            if (term) begin
                div_cnt <= {1'b0, div_nx} + (DIV_W + 1)'(carry);
                acc     <= acc_sum;
                phase   <= phase + 1'b1;
                ps_q    <= ps_nx;
                div_q   <= div_nx;
                frac_q  <= frac_nx;
            end else if (tick) begin
                div_cnt <= div_cnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_brg_frac.sv
// tb_uart_brg_frac: directed checks of reset, integer/fractional periods, enable, load and reload.
module tb_uart_brg_frac;
    logic       Clk = 1'b0;
    logic       Rst_N, En, Ld;
    logic [3:0] PS;
    logic [7:0] Div;
    logic [3:0] Frac;
    logic       CE_16x, CE_1x;
    int         cyc = 0;
    int         vecs = 0;
    int         errs = 0;
    int         k;

    uart_brg_frac dut (
        .Clk(Clk), .Rst_N(Rst_N), .En(En), .Ld(Ld),
        .PS(PS), .Div(Div), .Frac(Frac),
        .CE_16x(CE_16x), .CE_1x(CE_1x)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // called at a negedge; Ld is sampled at the next posedge, whose index lands in k
    task automatic do_ld(input int p, input int d, input int f);
        PS   = 4'(p);
        Div  = 8'(d);
        Frac = 4'(f);
        Ld   = 1'b1;
        @(negedge Clk);
        Ld = 1'b0;
        k  = cyc;
    endtask

    task automatic wait_ce(input bit one, output int at);
        at = -1;
        for (int i = 0; i < 1000 && at < 0; i++) begin
            @(negedge Clk);
            if (one ? CE_1x : CE_16x) at = cyc;
        end
    endtask

    task automatic test_reset;
        int r, t;
        Rst_N = 1'b0; En = 1'b1; Ld = 1'b0; PS = '0; Div = '0; Frac = '0;
        repeat (3) @(negedge Clk);
        vecs++; if (CE_16x !== 1'b0) begin errs++; $display("FAIL rst_ce16 got %b exp 0", CE_16x); end
        vecs++; if (CE_1x !== 1'b0) begin errs++; $display("FAIL rst_ce1 got %b exp 0", CE_1x); end
        Rst_N = 1'b1;
        r = cyc;
        wait_ce(1'b0, t);
        vecs++; if (t - r !== 1) begin errs++; $display("FAIL rst_first_ce got %0d exp 1", t - r); end
        #2 Rst_N = 1'b0;
        #1;
        vecs++; if (CE_16x !== 1'b0) begin errs++; $display("FAIL async_rst_ce16 got %b exp 0", CE_16x); end
        vecs++; if (CE_1x !== 1'b0) begin errs++; $display("FAIL async_rst_ce1 got %b exp 0", CE_1x); end
        @(negedge Clk);
        Rst_N = 1'b1;
    endtask

    task automatic test_zero;
        int n16, n1, f16, f1;
        n16 = 0; n1 = 0; f16 = -1; f1 = -1;
        do_ld(0, 0, 0);
        vecs++; if (CE_16x !== 1'b0) begin errs++; $display("FAIL ld_clears_ce got %b exp 0", CE_16x); end
        repeat (48) begin
            @(negedge Clk);
            if (CE_16x) begin n16++; if (f16 < 0) f16 = cyc; end
            if (CE_1x) begin n1++; if (f1 < 0) f1 = cyc; end
        end
        vecs++; if (f16 - k !== 1) begin errs++; $display("FAIL zero_first got %0d exp 1", f16 - k); end
        vecs++; if (n16 !== 48) begin errs++; $display("FAIL zero_ce16_count got %0d exp 48", n16); end
        vecs++; if (n1 !== 3) begin errs++; $display("FAIL zero_ce1_count got %0d exp 3", n1); end
        vecs++; if (f1 - k !== 16) begin errs++; $display("FAIL zero_ce1_first got %0d exp 16", f1 - k); end
    endtask

    task automatic test_int_div;
        int t0, t1, a, b;
        do_ld(12, 1, 0);
        wait_ce(1'b0, t0);
        vecs++; if (t0 - k !== 26) begin errs++; $display("FAIL int_first got %0d exp 26", t0 - k); end
        wait_ce(1'b0, t1);
        vecs++; if (t1 - t0 !== 26) begin errs++; $display("FAIL int_period got %0d exp 26", t1 - t0); end
        wait_ce(1'b1, a);
        vecs++; if (a - k !== 416) begin errs++; $display("FAIL ce1_first got %0d exp 416", a - k); end
        vecs++; if (CE_16x !== 1'b1) begin errs++; $display("FAIL ce1_coincident got %b exp 1", CE_16x); end
        wait_ce(1'b1, b);
        vecs++; if (b - a !== 416) begin errs++; $display("FAIL ce1_period got %0d exp 416", b - a); end
    endtask

    task automatic test_frac;
        int t[17];
        int p, e;
        do_ld(0, 3, 4);
        for (int j = 0; j < 17; j++) wait_ce(1'b0, t[j]);
        for (int j = 1; j <= 9; j++) begin
            p = t[j-1] - (j == 1 ? k : t[j-2]);
            e = (j > 1 && j % 4 == 1) ? 5 : 4;
            vecs++; if (p !== e) begin errs++; $display("FAIL frac_period%0d got %0d exp %0d", j, p, e); end
        end
        vecs++; if (t[16] - t[0] !== 68) begin errs++; $display("FAIL frac_sum16 got %0d exp 68", t[16] - t[0]); end
    endtask

    task automatic test_en_ld;
        int t0, t1, t2, t3, t4, n, e;
        En = 1'b1;
        do_ld(1, 4, 0);
        wait_ce(1'b0, t0);
        vecs++; if (t0 - k !== 10) begin errs++; $display("FAIL en_first got %0d exp 10", t0 - k); end
        repeat (3) @(negedge Clk);
        En = 1'b0;
        repeat (7) @(negedge Clk);
        En = 1'b1;
        wait_ce(1'b0, t1);
        vecs++; if (t1 - t0 !== 17) begin errs++; $display("FAIL en_hold got %0d exp 17", t1 - t0); end
        repeat (4) @(negedge Clk);
        do_ld(1, 4, 0);
        wait_ce(1'b0, t2);
        vecs++; if (t2 - k !== 10) begin errs++; $display("FAIL ld_mid got %0d exp 10", t2 - k); end
        repeat (9) @(negedge Clk);
        do_ld(1, 4, 0);
        vecs++; if (CE_16x !== 1'b0) begin errs++; $display("FAIL ld_vs_term_ce got %b exp 0", CE_16x); end
        wait_ce(1'b0, t3);
        vecs++; if (t3 - k !== 10) begin errs++; $display("FAIL ld_vs_term_restart got %0d exp 10", t3 - k); end
        En = 1'b0;
        do_ld(0, 1, 0);
        n = 0;
        repeat (5) begin @(negedge Clk); if (CE_16x) n++; end
        vecs++; if (n !== 0) begin errs++; $display("FAIL ld_en_low_ce got %0d exp 0", n); end
        En = 1'b1;
        e = cyc;
        wait_ce(1'b0, t4);
        vecs++; if (t4 - e !== 2) begin errs++; $display("FAIL ld_en_low_start got %0d exp 2", t4 - e); end
    endtask

    task automatic test_no_reload;
        int t0, t1, t2, t3, e2;
        do_ld(12, 1, 0);
        wait_ce(1'b0, t0);
        repeat (5) @(negedge Clk);
        Div = 8'd3;
        wait_ce(1'b0, t1);
        wait_ce(1'b0, t2);
`ifdef BRG_AUTO_RELOAD_EN
        e2 = 52;
`else
        e2 = 26;
`endif
        vecs++; if (t1 - t0 !== 26) begin errs++; $display("FAIL reload_cur got %0d exp 26", t1 - t0); end
        vecs++; if (t2 - t1 !== e2) begin errs++; $display("FAIL reload_next got %0d exp %0d", t2 - t1, e2); end
        do_ld(12, 3, 0);
        wait_ce(1'b0, t3);
        vecs++; if (t3 - k !== 52) begin errs++; $display("FAIL reload_ld got %0d exp 52", t3 - k); end
    endtask

    initial begin
        test_reset;
        test_zero;
        test_int_div;
        test_frac;
        test_en_ld;
        test_no_reload;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
